// File: rtl/capture_window_gate.sv
// capture_window_gate
// Trigger-aligned capture gate: once armed (and triggered, in level mode),
// skips SKIP_SAMPLES valid samples and then forwards CAPTURE_LEN decimated
// samples as a registered valid_out/data_out pair for a downstream writer.
module capture_window_gate #(
    parameter int DATA_WIDTH   = 10,
    parameter int SKIP_SAMPLES = 16,
    parameter int CAPTURE_LEN  = 1024,
    parameter int DECIM        = 1,
    parameter int TRIG_MODE    = 1,
    parameter int TRIG_LEVEL   = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  sample_cnt
);

    localparam logic [15:0] SKIP_L    = 16'(SKIP_SAMPLES);
    localparam logic [15:0] LEN_L     = 16'(CAPTURE_LEN);
    localparam logic [9:0]  DECIM_TOP = 10'(DECIM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TRIG,
        ST_SKIP,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t              state;
    logic [15:0]         skip_cnt;
    logic [9:0]          decim_cnt;

    logic [DATA_WIDTH:0] data_sext;
    logic [DATA_WIDTH:0] data_mag;
    logic                trig_hit;
    logic                take;
    logic [15:0]         cnt_inc;
    logic [15:0]         skip_inc;
    logic [9:0]          decim_next;

    // Magnitude, trigger detect and forward decision for the current sample.
    // With no skip window the trigger sample itself is the first capture.
    always_comb begin
        data_sext  = {data_in[DATA_WIDTH-1], data_in};
        data_mag   = data_in[DATA_WIDTH-1] ? (~data_sext + 1'b1) : data_sext;
        trig_hit   = valid_in && (32'(data_mag) >= 32'(TRIG_LEVEL));
        take       = ((state == ST_CAPTURE) && valid_in && (decim_cnt == '0)) ||
                     ((state == ST_WAIT_TRIG) && trig_hit && (SKIP_SAMPLES == 0));
        cnt_inc    = sample_cnt + 16'd1;
        skip_inc   = skip_cnt + 16'd1;
        decim_next = (decim_cnt == DECIM_TOP) ? '0 : decim_cnt + 10'd1;
    end

    // Window FSM with registered outputs; a forward that completes the
    // window overrides whatever state the case branch selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            valid_out  <= 1'b0;
            data_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
            skip_cnt   <= '0;
            decim_cnt  <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        sample_cnt <= '0;
                        skip_cnt   <= '0;
                        decim_cnt  <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        if (TRIG_MODE == 1)
                            state <= ST_WAIT_TRIG;
                        else if (SKIP_SAMPLES == 0)
                            state <= ST_CAPTURE;
                        else
                            state <= ST_SKIP;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_hit) begin
                        if (SKIP_SAMPLES == 0) begin
                            decim_cnt <= decim_next;
                            state     <= ST_CAPTURE;
                        end else begin
                            skip_cnt <= 16'd1;
                            state    <= (SKIP_L == 16'd1) ? ST_CAPTURE : ST_SKIP;
                        end
                    end
                end
                ST_SKIP: begin
                    if (valid_in) begin
                        skip_cnt <= skip_inc;
                        if (skip_inc == SKIP_L)
                            state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (valid_in)
                        decim_cnt <= decim_next;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase

            if (take) begin
                valid_out  <= 1'b1;
                data_out   <= data_in;
                sample_cnt <= cnt_inc;
                if (cnt_inc == LEN_L) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule
